// File: rtl/verificador_gray_pkg.sv
// Shared definitions for the Gray-link checker: FSM encoding and default sizes.
package verificador_gray_pkg;

   localparam int WIDTH_DEF      = 5;
   localparam int LOCK_COUNT_DEF = 4;
   localparam int ERR_W_DEF      = 8;

   typedef enum logic [1:0] {
      ESPERA       = 2'd0,
      ADQUIRIENDO  = 2'd1,
      SINCRONIZADO = 2'd2
   } estado_t;

endpackage

// File: rtl/verificador_gray_gray_a_binario.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray_a_binario #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   always_comb begin
      o_bin = i_gray;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         o_bin[i] = o_bin[i+1] ^ i_gray[i];
      end
   end

endmodule

// File: rtl/verificador_gray.sv
// Receiver side of the Gray-counter link: converts each enabled sample to binary and
// checks it is the previous accepted value plus one, reporting lock and sequence breaks.
//
// state        | meaning
// ESPERA       | no reference yet; next enabled sample becomes the reference
// ADQUIRIENDO  | counting consecutive correct increments toward lock
// SINCRONIZADO | locked; a break pulses error and drops back to ADQUIRIENDO
module verificador_gray
   import verificador_gray_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int LOCK_COUNT = LOCK_COUNT_DEF,
   parameter int ERR_W      = ERR_W_DEF
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             enable,
   input  logic [WIDTH-1:0] gray_in,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             sync,
   output logic             error,
   output logic [ERR_W-1:0] err_count
);

   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_COUNT - 1);

   estado_t          r_state;
   logic [WIDTH-1:0] r_ref;
   logic [CW-1:0]    r_match_cnt;
   logic [WIDTH-1:0] r_bin_out;
   logic             r_bin_valid;
   logic             r_sync;
   logic             r_error;
   logic [ERR_W-1:0] r_err_count;

   logic [WIDTH-1:0] w_bin;
   logic [WIDTH-1:0] w_exp;
   logic             w_match;

   gray_a_binario #(.WIDTH(WIDTH)) u_gray_a_binario (
      .i_gray (gray_in),
      .o_bin  (w_bin)
   );

   // Truncation makes the all-ones reference expect zero, so wrap-around is legal.
   assign w_exp   = r_ref + WIDTH'(1);
   assign w_match = (w_bin == w_exp);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_state     <= ESPERA;
         r_ref       <= '0;
         r_match_cnt <= '0;
         r_bin_out   <= '0;
         r_bin_valid <= 1'b0;
         r_sync      <= 1'b0;
         r_error     <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_bin_valid <= 1'b0;
         r_error     <= 1'b0;
         if (enable) begin
            r_bin_out   <= w_bin;
            r_bin_valid <= 1'b1;
            r_ref       <= w_bin;
            case (r_state)
               ESPERA: begin
                  r_match_cnt <= '0;
                  r_state     <= ADQUIRIENDO;
               end
               ADQUIRIENDO: begin
                  if (w_match) begin
                     r_match_cnt <= r_match_cnt + CW'(1);
                     if (r_match_cnt == LOCK_LAST) begin
                        r_state <= SINCRONIZADO;
                        r_sync  <= 1'b1;
                     end
                  end else begin
                     r_match_cnt <= '0;
                  end
               end
               SINCRONIZADO: begin
                  if (!w_match) begin
                     r_error     <= 1'b1;
                     r_sync      <= 1'b0;
                     r_match_cnt <= '0;
                     r_state     <= ADQUIRIENDO;
                     if (r_err_count != '1) begin
                        r_err_count <= r_err_count + ERR_W'(1);
                     end
                  end
               end
               default: begin
                  r_state     <= ESPERA;
                  r_sync      <= 1'b0;
                  r_match_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign bin_out   = r_bin_out;
   assign bin_valid = r_bin_valid;
   assign sync      = r_sync;
   assign error     = r_error;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_verificador_gray.sv
// Directed plus randomized bench for verificador_gray against a behavioural sequence model.
module tb_verificador_gray;

   localparam int W    = 5;
   localparam int LOCK = 4;
   localparam int EW   = 8;
   localparam int MODV = 1 << W;
   localparam int EMAX = (1 << EW) - 1;

   logic          clk;
   logic          reset_L;
   logic          enable;
   logic [W-1:0]  gray_in;
   logic [W-1:0]  bin_out;
   logic          bin_valid;
   logic          sync;
   logic          error;
   logic [EW-1:0] err_count;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit m_have;
   int m_prev;
   int m_streak;
   bit m_locked;
   int m_errs;
   int m_bin;
   bit m_valid;
   bit m_err;

   verificador_gray #(.WIDTH(W), .LOCK_COUNT(LOCK), .ERR_W(EW)) dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .enable    (enable),
      .gray_in   (gray_in),
      .bin_out   (bin_out),
      .bin_valid (bin_valid),
      .sync      (sync),
      .error     (error),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_have = 0; m_prev = 0; m_streak = 0; m_locked = 0;
      m_errs = 0; m_bin = 0; m_valid = 0; m_err = 0;
   endtask

   task automatic model_step(input bit en, input int b);
      m_valid = en;
      m_err   = 0;
      if (en) begin
         m_bin = b;
         if (m_have && b == (m_prev + 1) % MODV) begin
            if (!m_locked) begin
               m_streak++;
               if (m_streak == LOCK) m_locked = 1;
            end
         end else if (m_have) begin
            if (m_locked) begin
               m_err = 1;
               if (m_errs < EMAX) m_errs++;
            end
            m_locked = 0;
            m_streak = 0;
         end else begin
            m_streak = 0;
         end
         m_have = 1;
         m_prev = b;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".bin_out"},   int'(bin_out),   m_bin);
      chk({tag, ".bin_valid"}, int'(bin_valid), int'(m_valid));
      chk({tag, ".sync"},      int'(sync),      int'(m_locked));
      chk({tag, ".error"},     int'(error),     int'(m_err));
      chk({tag, ".err_count"}, int'(err_count), m_errs);
   endtask

   task automatic step(input bit en, input int b, input string tag);
      logic [W-1:0] bv;
      @(negedge clk);
      bv      = W'(b);
      enable  = en;
      gray_in = bv ^ (bv >> 1);
      @(posedge clk);
      #1;
      model_step(en, b);
      check_all(tag);
   endtask

   initial begin
      int cur;
      reset_L = 1'b0;
      enable  = 1'b0;
      gray_in = '0;
      model_reset();
      #2;
      check_all("reset");
      @(negedge clk);
      reset_L = 1'b1;

      // lock-up on 0..4: sync on 5th sample
      for (int i = 0; i <= 4; i++) step(1'b1, i, "lock_seq");
      chk("sync_after_5", int'(sync), 1);

      // enable gap between 5 and 6
      step(1'b1, 5, "pre_gap");
      for (int i = 0; i < 3; i++) step(1'b0, 13, "gap");
      step(1'b1, 6, "post_gap");
      chk("sync_hold_gap", int'(sync), 1);

      // break 7 -> 9, then relock on 13
      step(1'b1, 7, "pre_break");
      step(1'b1, 9, "break");
      chk("break_err", int'(error), 1);
      chk("break_cnt", int'(err_count), 1);
      for (int i = 10; i <= 13; i++) step(1'b1, i, "relock");
      chk("relock_sync", int'(sync), 1);

      // free run through wrap 31 -> 0
      for (int i = 14; i <= 33; i++) step(1'b1, i % MODV, "wrap");
      chk("wrap_no_err", int'(err_count), 1);

      // repeated sample while locked
      for (int i = 2; i <= 8; i++) step(1'b1, i, "pre_repeat");
      step(1'b1, 8, "repeat");
      chk("repeat_cnt", int'(err_count), 2);

      // relock and make a third break
      for (int i = 9; i <= 12; i++) step(1'b1, i, "relock2");
      step(1'b1, 20, "break3");
      for (int i = 21; i <= 24; i++) step(1'b1, i, "relock3");
      chk("pre_reset_sync", int'(sync), 1);
      chk("pre_reset_cnt", int'(err_count), 3);

      // asynchronous reset mid-cycle
      #2;
      reset_L = 1'b0;
      #1;
      model_reset();
      check_all("async_reset");
      @(negedge clk);
      reset_L = 1'b1;
      step(1'b1, 17, "first_after_reset");
      for (int i = 18; i <= 21; i++) step(1'b1, i, "relock_after_reset");

      // randomized traffic
      cur = 21;
      for (int n = 0; n < 400; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 2) begin
            step(1'b0, int'($urandom_range(0, MODV - 1)), "rnd_idle");
         end else if (r < 3) begin
            cur = int'($urandom_range(0, MODV - 1));
            step(1'b1, cur, "rnd_jump");
         end else begin
            cur = (cur + 1) % MODV;
            step(1'b1, cur, "rnd_inc");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/verificador_gray.md
Name: verificador_gray

Overview:
Receiving end of the Gray-counter link: samples the Gray-coded count driven by the Gray counter and converts it to binary. Checks that every enabled sample is exactly the previous value plus one (mod 2^WIDTH) and reports sync and error status. Sits opposite the counter in the same testbench/probador environment and serves as its synthesizable checker.

Parameters:
WIDTH, 5, width of the Gray count and of the binary output
LOCK_COUNT, 4, consecutive correct increments required to declare sync (range 1..15)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset_L  input  1  asynchronous, active-low reset
enable  input  1  qualifies gray_in; samples are taken only when high
gray_in  input  WIDTH  Gray-coded count from the counter
bin_out  output  WIDTH  registered binary equivalent of the last accepted sample
bin_valid  output  1  high for one cycle per accepted sample
sync  output  1  high while the link is locked
error  output  1  one-cycle pulse on a sequence break while locked
err_count  output  ERR_W  number of sequence breaks, saturating

Behaviour:
- Reset (reset_L=0, asynchronous): bin_out=0, bin_valid=0, sync=0, error=0, err_count=0, match_cnt=0, ref=0, state=ESPERA. Outputs go to these values immediately. Release is sampled at the next rising edge.
- Conversion: bin[W-1]=g[W-1]; bin[i]=bin[i+1]^g[i]. Purely combinational from gray_in, then registered. Latency is 1 cycle: a sample taken at edge N appears on bin_out/bin_valid after edge N.
- enable=0: no sample is taken. bin_valid=0, error=0, and all other state holds, including bin_out, sync and match_cnt. Gaps in enable do not break sync.
- Expected value: exp = ref + 1, truncated to WIDTH. ref = (2^WIDTH)-1 therefore expects 0, so wrap-around is legal. A repeated value is a mismatch.
- FSM, evaluated only on enabled samples:
  - ESPERA:
    - First sample: ref <= bin, match_cnt <= 0, go to ADQUIRIENDO. No error.
  - ADQUIRIENDO:
    - Match: ref <= bin, match_cnt++.
    - Match that makes match_cnt reach LOCK_COUNT: go to SINCRONIZADO and assert sync on that same edge.
    - Mismatch: ref <= bin, match_cnt <= 0, stay in ADQUIRIENDO. No error pulse and err_count unchanged, because errors are only counted while locked.
  - SINCRONIZADO:
    - Match: ref <= bin, stay.
    - Mismatch: error=1 for exactly that cycle, err_count++ (saturates at 2^ERR_W-1), sync <= 0, ref <= bin, match_cnt <= 0, go to ADQUIRIENDO. The offending sample counts as the new reference.
- bin_out and bin_valid update on every enabled sample regardless of state, including error samples.
- sync is a registered state flag: sync = (state==SINCRONIZADO).
- match_cnt is sized to $clog2(LOCK_COUNT+1) bits and never exceeds LOCK_COUNT.
- Reset mid-operation: everything returns to reset values. The next enabled sample after release is treated as a first sample, with no error.

Decomposition:
- Shared include verificador_gray_defs.v:
  - state encodings ESPERA=2'd0, ADQUIRIENDO=2'd1, SINCRONIZADO=2'd2 (2'd3 is illegal and recovers to ESPERA)
  - default WIDTH and LOCK_COUNT constants, also used by the probador
- One combinational sub-module, gray_a_binario (parameter WIDTH), instantiated once. The conditional RTL and the yosys-synthesized netlist are both compared in the testbench, as for the counter.

Test Plan:
- Reset, then enable=1 and feed Gray 0,1,3,2,6 (bin 0..4) -> bin_out 0..4 with 1-cycle latency; sync rises on the 5th sample's edge (LOCK_COUNT=4); error never asserts.
- Locked, free-running counter over bin 30,31,0,1 (Gray 10001,10000,00000,00001) -> no error on the 31->0 wrap; sync stays 1.
- Locked at bin 7, then inject Gray of bin 9 -> error=1 for one cycle, err_count=1, sync=0 next cycle. Then 10,11,12,13 -> sync re-asserts on the sample of bin 13.
- Locked, enable low for 3 cycles between bin 5 and bin 6 -> bin_valid=0 during the gap, sync holds 1, no error.
- Repeated sample (bin 8 twice) while locked -> error pulse, err_count increments.
- Assert reset_L=0 mid-cycle while locked with err_count=3 -> all outputs 0 immediately. After release, first sample gives no error and the lock sequence restarts. The synth netlist matches the conditional model cycle-for-cycle throughout.
